// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter run controller.
package counter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE
   } ctrl_state_t;

   localparam int unsigned PW = 8;

endpackage

// File: rtl/counter_en.sv
// N-bit up counter with async active-high reset, synchronous clear and enable.
module counter_en #(
   parameter int unsigned N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         en,
   output logic [N-1:0] q
);

   logic [N-1:0] cnt_q;
   logic [N-1:0] cnt_d;

   // Clear wins over enable so a reload never sees a stray increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + N'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/counter_sched.sv
// Run controller: sequences an N-bit counter from 0 to a latched limit,
// with stop/auto-reload at the limit, pause, abort and a saturating period count.
module counter_sched
   import counter_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = counter_pkg::PW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic          pause,
   input  logic          autoreload,
   input  logic [N-1:0]  limit,
   output logic [N-1:0]  q,
   output logic          busy,
   output logic          done,
   output logic [PW-1:0] periods
);

   ctrl_state_t   state_q, state_d;
   logic [N-1:0]  limit_q, limit_d;
   logic          auto_q, auto_d;
   logic          done_q, done_d;
   logic [PW-1:0] periods_q, periods_d;
   logic          cnt_clear;
   logic          cnt_en;
   logic [N-1:0]  cnt;

   counter_en #(
      .N (N)
   ) u_counter (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .en    (cnt_en),
      .q     (cnt)
   );

   always_comb begin
      state_d   = state_q;
      limit_d   = limit_q;
      auto_d    = auto_q;
      done_d    = 1'b0;
      periods_d = periods_q;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               limit_d   = limit;
               auto_d    = autoreload;
               periods_d = '0;
               cnt_clear = 1'b1;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               cnt_clear = 1'b1;
               state_d   = IDLE;
            end else if (pause) begin
               state_d = PAUSE;
            end else if (cnt == limit_q) begin
               done_d = 1'b1;
               if (periods_q != '1) begin
                  periods_d = periods_q + PW'(1);
               end
               // Non-reload runs park at the limit value rather than clearing.
               if (auto_q) begin
                  cnt_clear = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_en = 1'b1;
            end
         end
         PAUSE: begin
            if (stop) begin
               cnt_clear = 1'b1;
               state_d   = IDLE;
            end else if (!pause) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         limit_q   <= '0;
         auto_q    <= 1'b0;
         done_q    <= 1'b0;
         periods_q <= '0;
      end else begin
         state_q   <= state_d;
         limit_q   <= limit_d;
         auto_q    <= auto_d;
         done_q    <= done_d;
         periods_q <= periods_d;
      end
   end

   assign q       = cnt;
   assign busy    = (state_q == RUN) || (state_q == PAUSE);
   assign done    = done_q;
   assign periods = periods_q;

endmodule
